// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit multiplexed hex display driver for a 32-bit debug word
//
// Purpose: latches a 32-bit word and scans its eight hex nibbles onto an
// 8-digit common-anode seven-segment display, one digit per CLK_DIV cycles.
//
// Ports:
//   clk_in       - system clock, the only clock
//   reset        - asynchronous active-high reset, display goes dark
//   i_enable     - 1 = display on, 0 = all digits dark
//   i_data_store - latch i_data on this edge
//   i_data       - word to show; nibble k drives digit k (digit 0 rightmost)
//   i_dp_mask    - bit k lights the decimal point of digit k
//   o_seg        - active-low segments, [7]=dp, [6:0]=g f e d c b a
//   o_sel        - active-low digit anodes, bit k = digit k
module seg7_scan_display #(
    parameter int CLK_DIV  = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_data_store,
    input  logic [31:0] i_data,
    input  logic [7:0]  i_dp_mask,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    // Minimum width that holds CLK_DIV-1.
    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      word_q, word_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       sel_q, sel_d;

    logic             tick;
    logic [3:0]       nibble;
    logic [2:0]       top_digit;
    logic             blank;
    logic [6:0]       code;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return c;
    endfunction

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = tick ? idx_q + 3'd1 : idx_q;
        word_d    = i_data_store ? i_data : word_q;

        nibble = 4'(word_q >> {idx_q, 2'b00});

        // Highest non-zero nibble; stays 0 for an all-zero word so digit 0
        // is never blanked.
        top_digit = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (word_q[4*k +: 4] != 4'h0) begin
                top_digit = 3'(k);
            end
        end
        blank = BLANK_LZ && (idx_q > top_digit);
        code  = blank ? 7'h7F : hex_decode(nibble);

        // Both output registers are loaded from the same idx_q so the anode
        // and its segments always switch on the same edge.
        if (i_enable) begin
            sel_d = ~(8'h01 << idx_q);
            seg_d = {~i_dp_mask[idx_q], code};
        end else begin
            sel_d = 8'hFF;
            seg_d = 8'hFF;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            idx_q     <= 3'd0;
            word_q    <= 32'h0;
            seg_q     <= 8'hFF;
            sel_q     <= 8'hFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
        end
    end

    assign o_seg = seg_q;
    assign o_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

    localparam int DIV = 4;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_data_store = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic [7:0]  i_dp_mask = 8'h00;
    logic [7:0]  seg0, sel0, seg1, sel1;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: edges since reset, digit shown, stored word.
    int          m_n;
    int          m_idx;
    int          shown_idx;
    logic [31:0] m_word;

    bit [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_display #(.CLK_DIV(DIV), .BLANK_LZ(1'b0)) u_dut_plain (
        .clk_in(clk_in), .reset(reset), .i_enable(i_enable), .i_data_store(i_data_store),
        .i_data(i_data), .i_dp_mask(i_dp_mask), .o_seg(seg0), .o_sel(sel0)
    );

    seg7_scan_display #(.CLK_DIV(DIV), .BLANK_LZ(1'b1)) u_dut_blank (
        .clk_in(clk_in), .reset(reset), .i_enable(i_enable), .i_data_store(i_data_store),
        .i_data(i_data), .i_dp_mask(i_dp_mask), .o_seg(seg1), .o_sel(sel1)
    );

    always #5 clk_in = ~clk_in;

    // A digit is a leading zero when it and every digit above it are zero.
    function automatic logic [7:0] model_seg(input logic [31:0] w, input int idx,
                                             input logic en, input logic [7:0] dp, input bit lz);
        logic [31:0] upper;
        logic [6:0]  c;
        if (!en) return 8'hFF;
        upper = w >> (4 * idx);
        if (lz && idx != 0 && upper == 32'h0) c = 7'h7F;
        else c = hex_tab[upper & 32'hF];
        return {~dp[idx], c};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_idx = 0; m_word = 32'h0; shown_idx = 0;
    endtask

    // One clock edge: outputs after edge n reflect the state after edge n-1.
    task automatic do_cycle();
        logic        en, st;
        logic [7:0]  dp, e_sel;
        logic [31:0] d;
        en = i_enable; st = i_data_store; dp = i_dp_mask; d = i_data;
        @(posedge clk_in);
        #1;
        shown_idx = m_idx;
        e_sel = en ? ~(8'h01 << m_idx) : 8'hFF;
        check("sel_plain", sel0, e_sel);
        check("sel_blank", sel1, e_sel);
        check("seg_plain", seg0, model_seg(m_word, m_idx, en, dp, 1'b0));
        check("seg_blank", seg1, model_seg(m_word, m_idx, en, dp, 1'b1));
        m_n++;
        m_idx = (m_n / DIV) % 8;
        if (st) m_word = d;
    endtask

    task automatic store(input logic [31:0] w);
        i_data = w; i_data_store = 1'b1;
        do_cycle();
        i_data_store = 1'b0;
    endtask

    // lit holds the literal segment byte for digit k at [8k +: 8].
    task automatic frame_check(input logic [63:0] lit, input bit lz, input string tag);
        for (int i = 0; i < 8 * DIV; i++) begin
            do_cycle();
            check(tag, lz ? seg1 : seg0, lit[8 * shown_idx +: 8]);
        end
    endtask

    initial begin
        bit seen1;
        bit found;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_sel", sel0, 8'hFF);
        check("reset_seg", seg0, 8'hFF);
        reset = 1'b0;

        // Scenario 1
        store(32'h00400000);
        do_cycle();
        check("s1_sel0", sel0, 8'hFE);
        check("s1_seg0", seg0, 8'hC0);
        seen1 = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            do_cycle();
            if (shown_idx == 1 && !seen1) begin
                seen1 = 1;
                check("s1_sel1", sel0, 8'hFD);
                check("s1_seg1", seg0, 8'hC0);
            end
            if (shown_idx == 5) begin
                found = 1;
                check("s1_sel5", sel0, 8'hDF);
                check("s1_seg5", seg0, 8'h99);
            end
        end
        check("s1_reached5", {7'h0, found}, 8'h01);

        // Scenario 2
        store(32'h89ABCDEF);
        frame_check(64'h80908883C6A1868E, 1'b0, "s2_plain");
        frame_check(64'h80908883C6A1868E, 1'b1, "s2_blank");

        // Scenario 3
        store(32'h0000001F);
        frame_check(64'hFFFFFFFFFFFFF98E, 1'b1, "s3_blank_1f");
        frame_check(64'hC0C0C0C0C0C0F98E, 1'b0, "s3_plain_1f");
        store(32'h0);
        frame_check(64'hFFFFFFFFFFFFFFC0, 1'b1, "s3_blank_0");

        // Scenario 4
        i_dp_mask = 8'h04;
        frame_check(64'hC0C0C0C0C040C0C0, 1'b0, "s4_dp");
        i_dp_mask = 8'h00;

        // Scenario 5
        store(32'h13572468);
        i_enable = 1'b0;
        repeat (10) do_cycle();
        check("s5_dark_sel", sel0, 8'hFF);
        check("s5_dark_seg", seg0, 8'hFF);
        i_enable = 1'b1;
        repeat (6) do_cycle();

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            i_data_store = ($urandom_range(0, 3) == 0);
            i_data = $urandom() >> (4 * $urandom_range(0, 8));
            i_enable = ($urandom_range(0, 7) != 0);
            i_dp_mask = 8'($urandom());
            do_cycle();
        end
        i_data_store = 1'b0; i_enable = 1'b1; i_dp_mask = 8'h00;
        store(32'h76543210);

        // Scenario 6: asynchronous reset while digit 3 is lit
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            do_cycle();
            if (shown_idx == 3) found = 1;
        end
        check("s6_reached3", {7'h0, found}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("s6_async_sel0", sel0, 8'hFF);
        check("s6_async_seg0", seg0, 8'hFF);
        check("s6_async_sel1", sel1, 8'hFF);
        check("s6_async_seg1", seg1, 8'hFF);
        #1 reset = 1'b0;
        model_reset();
        do_cycle();
        check("s6_restart_sel", sel0, 8'hFE);
        check("s6_restart_seg", seg0, 8'hC0);
        repeat (2) do_cycle();
        store(32'h000000A0);
        do_cycle();
        check("s6_tick_store_sel", sel0, 8'hFD);
        check("s6_tick_store_seg", seg0, 8'h88);
        repeat (8) do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
